// File: rtl/axi4_interface.sv
// axi4_interface: AXI4 subset used between the core's master and its SRAM target.
// Single ID, INCR-only; protection and clock/reset members exist for the master's benefit.
interface axi4_interface #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    logic                      m_aclk;
    logic                      m_aresetn;
    logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
    logic [7:0]                m_awlen;
    logic [2:0]                m_awprot;
    logic                      m_awvalid;
    logic                      s_awready;
    logic [AXI_DATA_WIDTH-1:0] m_wdata;
    logic                      m_wlast;
    logic                      m_wvalid;
    logic                      s_wready;
    logic                      s_bvalid;
    logic                      m_bready;
    logic [AXI_ADDR_WIDTH-1:0] m_araddr;
    logic [7:0]                m_arlen;
    logic [2:0]                m_arprot;
    logic                      m_arvalid;
    logic                      s_arready;
    logic [AXI_DATA_WIDTH-1:0] s_rdata;
    logic                      s_rvalid;
    logic                      m_rready;

    modport master (
        output m_aclk, m_aresetn, m_awaddr, m_awlen, m_awprot, m_awvalid, m_wdata, m_wlast,
               m_wvalid, m_bready, m_araddr, m_arlen, m_arprot, m_arvalid, m_rready,
        input  s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid
    );

    modport slave (
        input  m_aclk, m_aresetn, m_awaddr, m_awlen, m_awprot, m_awvalid, m_wdata, m_wlast,
               m_wvalid, m_bready, m_araddr, m_arlen, m_arprot, m_arvalid, m_rready,
        output s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid
    );
endinterface

// File: rtl/axi_sram_responder.sv
// axi_sram_responder: one-burst-at-a-time AXI4 slave over an internal word-addressed SRAM.
// Write wins over read in IDLE; wlast framing violations latch on protocol_error.
module axi_sram_responder #(
    parameter int MEM_WORDS      = 1024,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    axi4_interface.slave  axi_bus,
    output logic          protocol_error
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] READ_BURST = 2'd1;
    localparam logic [1:0] WRITE_DATA = 2'd2;
    localparam logic [1:0] WRITE_RESP = 2'd3;

    logic [1:0]                r_state;
    logic [IW-1:0]             r_idx;
    logic [7:0]                r_len;
    logic [7:0]                r_cnt;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic          w_idle;
    logic          w_last;
    logic          w_aw_hs;
    logic          w_ar_hs;
    logic          w_w_hs;
    logic          w_r_hs;
    logic          w_b_hs;
    logic [IW-1:0] w_idx_nxt;
    logic [IW-1:0] w_aw_idx;
    logic [IW-1:0] w_ar_idx;

    // reset_n gating keeps every ready/valid low while reset is held, even though IDLE is the reset state
    assign w_idle            = reset_n && r_state == IDLE;
    assign axi_bus.s_awready = w_idle;
    assign axi_bus.s_arready = w_idle && !axi_bus.m_awvalid;
    assign axi_bus.s_wready  = reset_n && r_state == WRITE_DATA;
    assign axi_bus.s_rvalid  = reset_n && r_state == READ_BURST;
    assign axi_bus.s_bvalid  = reset_n && r_state == WRITE_RESP;
    assign axi_bus.s_rdata   = r_rdata;

    assign w_aw_hs   = w_idle && axi_bus.m_awvalid;
    assign w_ar_hs   = axi_bus.s_arready && axi_bus.m_arvalid;
    assign w_w_hs    = axi_bus.s_wready && axi_bus.m_wvalid;
    assign w_r_hs    = axi_bus.s_rvalid && axi_bus.m_rready;
    assign w_b_hs    = axi_bus.s_bvalid && axi_bus.m_bready;
    assign w_last    = r_cnt == r_len;
    assign w_idx_nxt = r_idx + 1'b1;
    assign w_aw_idx  = axi_bus.m_awaddr[IW+1:2];
    assign w_ar_idx  = axi_bus.m_araddr[IW+1:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_len          <= '0;
            r_cnt          <= '0;
            r_rdata        <= '0;
            protocol_error <= 1'b0;
        end else if (w_aw_hs) begin
            r_state <= WRITE_DATA;
            r_idx   <= w_aw_idx;
            r_len   <= axi_bus.m_awlen;
            r_cnt   <= '0;
        end else if (w_ar_hs) begin
            r_state <= READ_BURST;
            r_idx   <= w_ar_idx;
            r_len   <= axi_bus.m_arlen;
            r_cnt   <= '0;
            r_rdata <= r_mem[w_ar_idx];
        end else if (w_r_hs) begin
            if (w_last) begin
                r_state <= IDLE;
            end else begin
                r_idx   <= w_idx_nxt;
                r_cnt   <= r_cnt + 8'd1;
                r_rdata <= r_mem[w_idx_nxt];
            end
        end else if (w_w_hs) begin
            r_idx <= w_idx_nxt;
            r_cnt <= r_cnt + 8'd1;
            if (w_last) r_state <= WRITE_RESP;
            // the burst length is authoritative; wlast is only checked against it
            if (axi_bus.m_wlast != w_last) protocol_error <= 1'b1;
        end else if (w_b_hs) begin
            r_state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_hs) r_mem[r_idx] <= axi_bus.m_wdata;
    end
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: randomized and directed bursts against an array model of the SRAM.
// All driving and sampling happens around the falling edge, away from the active rising edge.
module tb_axi_sram_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic protocol_error;
    int checks = 0;
    int errors = 0;
    logic [31:0] model [1024];
    bit          known [1024];
    logic [31:0] wr_buf [256];
    logic [31:0] rd_buf [256];
    bit op_ok, b_imm, ready_after, r_first, r_stable;

    axi4_interface bus ();

    axi_sram_responder #(.MEM_WORDS(1024), .AXI_DATA_WIDTH(32)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .axi_bus(bus),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned widx(input logic [31:0] addr, input int i);
        return ((int'(addr >> 2)) + i) % 1024;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int stall, input int bad);
        int n;
        bit hs;
        op_ok = 1'b1;
        bus.m_awaddr = addr;
        bus.m_awlen = 8'(len);
        bus.m_awvalid = 1'b1;
        n = 0;
        do begin #1 hs = bus.s_awready; @(negedge clk); n++; end while (!hs && n < 50);
        bus.m_awvalid = 1'b0;
        if (!hs) op_ok = 1'b0;
        for (int i = 0; i <= len && op_ok; i++) begin
            repeat (stall) @(negedge clk);
            bus.m_wdata = wr_buf[i];
            bus.m_wlast = (i == len) ^ (i == bad);
            bus.m_wvalid = 1'b1;
            n = 0;
            do begin #1 hs = bus.s_wready; @(negedge clk); n++; end while (!hs && n < 50);
            bus.m_wvalid = 1'b0;
            bus.m_wlast = 1'b0;
            if (!hs) op_ok = 1'b0;
            model[widx(addr, i)] = wr_buf[i];
            known[widx(addr, i)] = 1'b1;
        end
        #1 b_imm = bus.s_bvalid;
        bus.m_bready = 1'b1;
        n = 0;
        do begin #1 hs = bus.s_bvalid; @(negedge clk); n++; end while (!hs && n < 50);
        bus.m_bready = 1'b0;
        if (!hs) op_ok = 1'b0;
        #1 ready_after = bus.s_awready;
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input int stall);
        int n;
        bit hs;
        logic [31:0] hold;
        op_ok = 1'b1;
        r_stable = 1'b1;
        bus.m_araddr = addr;
        bus.m_arlen = 8'(len);
        bus.m_arvalid = 1'b1;
        n = 0;
        do begin #1 hs = bus.s_arready; @(negedge clk); n++; end while (!hs && n < 50);
        bus.m_arvalid = 1'b0;
        if (!hs) op_ok = 1'b0;
        #1 r_first = bus.s_rvalid;
        for (int i = 0; i <= len && op_ok; i++) begin
            if (i > 0) begin
                hold = bus.s_rdata;
                repeat (stall) begin
                    @(negedge clk);
                    #1 if (bus.s_rdata !== hold || bus.s_rvalid !== 1'b1) r_stable = 1'b0;
                end
            end
            bus.m_rready = 1'b1;
            n = 0;
            do begin #1 hs = bus.s_rvalid; rd_buf[i] = bus.s_rdata; @(negedge clk); n++; end
            while (!hs && n < 50);
            bus.m_rready = 1'b0;
            if (!hs) op_ok = 1'b0;
        end
        #1 ready_after = bus.s_arready;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.s_awready, bus.s_arready, bus.s_wready, bus.s_rvalid, bus.s_bvalid, protocol_error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", {bus.s_awready, bus.s_arready,
                     bus.s_wready, bus.s_rvalid, bus.s_bvalid, protocol_error});
        end
        checks++;
        if (bus.s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 00000000", bus.s_rdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({bus.s_awready, bus.s_arready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 11", {bus.s_awready, bus.s_arready});
        end
    endtask

    task automatic test_single();
        wr_buf[0] = 32'hDEADBEEF;
        do_write(32'h40, 0, 0, -1);
        checks++;
        if ({op_ok, b_imm, ready_after} !== 3'b111) begin
            errors++;
            $display("FAIL single_write_timing: got ok/bvalid/awready %b expected 111", {op_ok, b_imm, ready_after});
        end
        do_read(32'h40, 0, 0);
        checks++;
        if ({op_ok, r_first, ready_after} !== 3'b111) begin
            errors++;
            $display("FAIL single_read_timing: got ok/rvalid/arready %b expected 111", {op_ok, r_first, ready_after});
        end
        checks++;
        if (rd_buf[0] !== 32'hDEADBEEF || protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL single_read_data: got %h err %b expected deadbeef err 0", rd_buf[0], protocol_error);
        end
    endtask

    task automatic test_burst_stall();
        for (int i = 0; i < 4; i++) wr_buf[i] = 32'(i + 1);
        do_write(32'h100, 3, 1, -1);
        checks++;
        if ({op_ok, b_imm} !== 2'b11) begin
            errors++;
            $display("FAIL burst_write: got ok/bvalid %b expected 11", {op_ok, b_imm});
        end
        do_read(32'h100, 3, 2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_buf[i] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL burst_beat%0d: got %h expected %h", i, rd_buf[i], 32'(i + 1));
            end
        end
        checks++;
        if ({op_ok, r_stable} !== 2'b11) begin
            errors++;
            $display("FAIL burst_stall_stable: got ok/stable %b expected 11", {op_ok, r_stable});
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        wr_buf[0] = $urandom;
        do_write(32'h8, 0, 0, -1);
        d = $urandom;
        bus.m_awaddr = 32'h0;
        bus.m_awlen = 8'd0;
        bus.m_awvalid = 1'b1;
        bus.m_araddr = 32'h8;
        bus.m_arlen = 8'd0;
        bus.m_arvalid = 1'b1;
        #1;
        checks++;
        if ({bus.s_awready, bus.s_arready} !== 2'b10) begin
            errors++;
            $display("FAIL simul_priority: got aw/ar ready %b expected 10", {bus.s_awready, bus.s_arready});
        end
        @(negedge clk);
        bus.m_awvalid = 1'b0;
        bus.m_wdata = d;
        bus.m_wlast = 1'b1;
        bus.m_wvalid = 1'b1;
        #1;
        checks++;
        if ({bus.s_wready, bus.s_arready} !== 2'b10) begin
            errors++;
            $display("FAIL simul_wdata: got wready/arready %b expected 10", {bus.s_wready, bus.s_arready});
        end
        @(negedge clk);
        bus.m_wvalid = 1'b0;
        bus.m_wlast = 1'b0;
        model[0] = d;
        known[0] = 1'b1;
        bus.m_bready = 1'b1;
        #1;
        checks++;
        if ({bus.s_bvalid, bus.s_arready} !== 2'b10) begin
            errors++;
            $display("FAIL simul_bresp: got bvalid/arready %b expected 10", {bus.s_bvalid, bus.s_arready});
        end
        @(negedge clk);
        bus.m_bready = 1'b0;
        #1;
        checks++;
        if (bus.s_arready !== 1'b1) begin
            errors++;
            $display("FAIL simul_ar_after_b: got arready %b expected 1", bus.s_arready);
        end
        @(negedge clk);
        bus.m_arvalid = 1'b0;
        bus.m_rready = 1'b1;
        #1;
        checks++;
        if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== model[2]) begin
            errors++;
            $display("FAIL simul_read: got rvalid %b data %h expected 1 %h", bus.s_rvalid, bus.s_rdata, model[2]);
        end
        @(negedge clk);
        bus.m_rready = 1'b0;
        do_read(32'h0, 0, 0);
        checks++;
        if (rd_buf[0] !== d) begin
            errors++;
            $display("FAIL simul_write_data: got %h expected %h", rd_buf[0], d);
        end
    endtask

    task automatic test_wrap();
        wr_buf[0] = 32'hAAAA0001;
        wr_buf[1] = 32'hBBBB0002;
        do_write(32'hFFC, 1, 0, -1);
        do_read(32'h0, 0, 0);
        checks++;
        if (rd_buf[0] !== 32'hBBBB0002) begin
            errors++;
            $display("FAIL wrap_low: got %h expected bbbb0002", rd_buf[0]);
        end
        do_read(32'hFFC, 0, 0);
        checks++;
        if (rd_buf[0] !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL wrap_high: got %h expected aaaa0001", rd_buf[0]);
        end
    endtask

    task automatic test_wlast_errors();
        for (int i = 0; i < 3; i++) wr_buf[i] = $urandom;
        do_write(32'h200, 2, 0, 1);
        checks++;
        if ({protocol_error, b_imm, op_ok} !== 3'b111) begin
            errors++;
            $display("FAIL wlast_early: got err/bvalid/ok %b expected 111", {protocol_error, b_imm, op_ok});
        end
        wr_buf[0] = $urandom;
        do_write(32'h300, 0, 0, -1);
        checks++;
        if (protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL wlast_sticky: got %b expected 1", protocol_error);
        end
        do_reset();
        #1;
        checks++;
        if (protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL wlast_reset_clear: got %b expected 0", protocol_error);
        end
        for (int i = 0; i < 2; i++) wr_buf[i] = $urandom;
        do_write(32'h210, 1, 0, 1);
        checks++;
        if ({protocol_error, b_imm} !== 2'b11) begin
            errors++;
            $display("FAIL wlast_missing: got err/bvalid %b expected 11", {protocol_error, b_imm});
        end
        do_reset();
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 8; i++) wr_buf[i] = $urandom;
        do_write(32'h400, 7, 0, -1);
        bus.m_araddr = 32'h400;
        bus.m_arlen = 8'd7;
        bus.m_arvalid = 1'b1;
        @(negedge clk);
        bus.m_arvalid = 1'b0;
        bus.m_rready = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        bus.m_rready = 1'b0;
        #1;
        checks++;
        if ({bus.s_awready, bus.s_arready, bus.s_wready, bus.s_rvalid, bus.s_bvalid, protocol_error} !== 6'b0
            || bus.s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b data %h expected 000000 data 0", {bus.s_awready,
                     bus.s_arready, bus.s_wready, bus.s_rvalid, bus.s_bvalid, protocol_error}, bus.s_rdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({bus.s_awready, bus.s_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_release: got awready/rvalid %b expected 10", {bus.s_awready, bus.s_rvalid});
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.s_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stray_rvalid: got %b expected 0", bus.s_rvalid);
        end
        do_read(32'h400, 7, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_buf[i] !== model[widx(32'h400, i)]) begin
                errors++;
                $display("FAIL midreset_reread%0d: got %h expected %h", i, rd_buf[i], model[widx(32'h400, i)]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int len;
        for (int t = 0; t < 25; t++) begin
            addr = $urandom;
            len = $urandom_range(0, 15);
            for (int i = 0; i <= len; i++) wr_buf[i] = $urandom;
            do_write(addr, len, $urandom_range(0, 2), -1);
            checks++;
            if ({op_ok, b_imm, ready_after} !== 3'b111) begin
                errors++;
                $display("FAIL rand_write%0d: got ok/bvalid/awready %b expected 111", t, {op_ok, b_imm, ready_after});
            end
            addr = addr + 32'(4 * $urandom_range(0, 8)) - 32'd16;
            len = $urandom_range(0, 15);
            do_read(addr, len, $urandom_range(0, 2));
            checks++;
            if ({op_ok, r_first, r_stable, ready_after} !== 4'b1111) begin
                errors++;
                $display("FAIL rand_read%0d: got ok/rvalid/stable/arready %b expected 1111", t,
                         {op_ok, r_first, r_stable, ready_after});
            end
            for (int i = 0; i <= len; i++) begin
                if (known[widx(addr, i)]) begin
                    checks++;
                    if (rd_buf[i] !== model[widx(addr, i)]) begin
                        errors++;
                        $display("FAIL rand_data%0d_%0d: got %h expected %h", t, i, rd_buf[i], model[widx(addr, i)]);
                    end
                end
            end
        end
        checks++;
        if (protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL rand_no_error: got %b expected 0", protocol_error);
        end
    endtask

    initial begin
        bus.m_aclk = 1'b0;
        bus.m_aresetn = 1'b1;
        bus.m_awaddr = '0;
        bus.m_awlen = '0;
        bus.m_awprot = '0;
        bus.m_awvalid = 1'b0;
        bus.m_wdata = '0;
        bus.m_wlast = 1'b0;
        bus.m_wvalid = 1'b0;
        bus.m_bready = 1'b0;
        bus.m_araddr = '0;
        bus.m_arlen = '0;
        bus.m_arprot = '0;
        bus.m_arvalid = 1'b0;
        bus.m_rready = 1'b0;
        for (int i = 0; i < 1024; i++) known[i] = 1'b0;
        test_reset();
        test_single();
        test_burst_stall();
        test_simultaneous();
        test_wrap();
        test_wlast_errors();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_sram_responder.md
# axi_sram_responder

AXI4 slave (responder) backed by an internal word-addressed SRAM, connecting to the `axi4_interface.slave` modport. It terminates one read or write burst at a time, with fixed write-over-read priority. It is the simulation and FPGA memory target for the core's AXI master. It also flags `m_wlast` framing violations on a sticky error output.

## Interface
- `MEM_WORDS`, default 1024: memory depth in `AXI_DATA_WIDTH`-bit words; must be a power of two.
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset. The interface's `m_aclk` and `m_aresetn` are ignored.
- `axi_bus`  slave modport  –  `axi4_interface.slave`.
  - Used fields: `m_awaddr`, `m_awlen`, `m_awvalid`, `s_awready`, `m_wdata`, `m_wlast`, `m_wvalid`, `s_wready`, `s_bvalid`, `m_bready`, `m_araddr`, `m_arlen`, `m_arvalid`, `s_arready`, `s_rdata`, `s_rvalid`, `m_rready`.
  - `m_awprot` and `m_arprot` are ignored.
- `protocol_error`  out  1  sticky; set on any `m_wlast` mismatch.

## Operation
- **States:** IDLE, READ_BURST, WRITE_DATA, WRITE_RESP.
- **Word index:** `addr[2 + log2(MEM_WORDS) - 1 : 2]`. Upper bits and `addr[1:0]` are ignored.
- **Bursts:** all bursts are INCR with `len + 1` beats (1 to 256). The index increments by 1 per beat and wraps modulo `MEM_WORDS`.
- **IDLE:**
  - `s_awready` = 1.
  - `s_arready` = `!m_awvalid`: write has fixed priority when both requests are valid.
  - AW handshake: latch index and len, clear the beat counter, go to WRITE_DATA.
  - AR handshake: latch index and len, read `mem[index]` into the `s_rdata` register, go to READ_BURST.
- **READ_BURST:**
  - `s_rvalid` = 1.
  - On `m_rready`: if the beat counter equals len, go to IDLE. Otherwise increment index and counter, and load the next word into `s_rdata`.
  - `s_rdata` is held stable while `m_rready` = 0.
- **WRITE_DATA:**
  - `s_wready` = 1.
  - Each `m_wvalid` beat writes `m_wdata` to `mem[index]`, then increments index and counter.
  - The beat where counter equals len is the last beat; go to WRITE_RESP.
  - `protocol_error` sets if `m_wlast` = 1 on a non-last beat, or `m_wlast` = 0 on the last beat. The burst still completes on count.
- **WRITE_RESP:**
  - `s_bvalid` = 1 until `m_bready`, then go to IDLE.
- **Ordering:** the write is committed before `s_bvalid` rises, so a subsequent read sees the written data.
- **Error clearing:** `protocol_error` clears only on reset.
- **Memory:** contents are not reset. Unwritten words are undefined (X in simulation).

## Timing
- **Reset (`reset_n` low):**
  - State goes to IDLE.
  - `s_awready`, `s_arready`, `s_wready`, `s_rvalid`, `s_bvalid`, `protocol_error` all = 0 while `reset_n` is low.
  - `s_rdata` = 0.
  - The first cycle after release has `s_awready` = 1.
- **Reset mid-burst:** the transaction is abandoned with no `s_bvalid` and no further `s_rvalid`. Memory keeps any beats already written.
- **Read latency:**
  - AR handshake at cycle N gives `s_rvalid` = 1 with beat 0 at N+1.
  - A beat handshake at cycle M presents the next beat at M+1, so back-to-back streaming runs at 1 beat per cycle.
  - The final R handshake at P returns to IDLE, with `s_arready` possible at P+1.
- **Write latency:**
  - AW handshake at cycle N gives `s_wready` at N+1.
  - Last W beat at M gives `s_bvalid` at M+1.
  - B handshake at P gives `s_awready` at P+1.
- **Ready/valid timing:** `s_awready`, `s_arready`, `s_wready`, `s_rvalid`, `s_bvalid` are decoded from the registered state only; `s_arready` alone also depends combinationally on `m_awvalid`. No other combinational input-to-output path exists.
- **Simultaneous AW and AR in IDLE:** write is accepted; AR waits, with `s_arready` = 0, until IDLE is re-entered.
- **Minimum single-beat turnaround:** write is 3 cycles (AW, W, B). Read is 2 cycles (AR, R).

## Test plan
- **Single-beat write then read:** write `0xDEADBEEF` to 0x40 with len=0, `m_wlast`=1 → `s_bvalid` 1 cycle after the W beat. Then read 0x40 with len=0 → `s_rdata` = `0xDEADBEEF` 1 cycle after AR; `protocol_error` = 0.
- **4-beat burst with stalls:** write 1, 2, 3, 4 at 0x100 with len=3, idling `m_wvalid` between beats. Read back with `m_rready` toggling 1,0,0,1,... → beats 1, 2, 3, 4 in order; `s_rdata` stable during stalls.
- **Simultaneous AW and AR:** assert AW (0x0) and AR (0x8) in the same cycle → `s_arready` = 0 and the write completes first. The read is accepted in the first cycle after the B handshake.
- **Address wrap-around:** `MEM_WORDS` = 1024; write a len=1 burst at 0xFFC with data A, B → a read at 0x0 returns B, and a read at 0xFFC returns A.
- **wlast framing errors:**
  - len=2 with `m_wlast` on beat 1 → `protocol_error` = 1 and stays 1; `s_bvalid` still rises after beat 2.
  - A separate run with `m_wlast` missing on the last beat → also sets `protocol_error`.
- **Reset mid-burst:** pulse `reset_n` low during beat 2 of an 8-beat read → all outputs = 0 immediately. After release, `s_awready` = 1, no stray `s_rvalid`, and a new read returns correct data.
